alu_issue: RTL and testbench

Issue/operand-fetch stage directly upstream of `alu`. Accepts decoded register-register or register-immediate operations over a valid/ready handshake, reads a 16×16 register file, resolves read-after-write hazards against the two in-flight slots, and drives `alu` ctrl/a/b. It also captures `alu` result y and writes it back, closing the execute loop of the CPU.

---
 rtl/constants.sv | 23 ++
 rtl/regfile.sv | 31 +++
 rtl/alu_issue.sv | 98 +++++++++
 tb/tb_alu_issue.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/constants.sv
// Shared constants for the issue stage and the ALU it feeds.
// ALU op codes, datapath sizes and the issue-slot bundle.
package constants;
  localparam int W     = 16;
  localparam int NREGS = 16;
  localparam int IDXW  = $clog2(NREGS);

  localparam logic [3:0] ALU_OP_ADD = 4'h0;
  localparam logic [3:0] ALU_OP_SUB = 4'h1;
  localparam logic [3:0] ALU_OP_AND = 4'h2;
  localparam logic [3:0] ALU_OP_OR  = 4'h3;
  localparam logic [3:0] ALU_OP_XOR = 4'h4;

  typedef struct packed {
    logic            valid;
    logic [3:0]      op;
    logic [IDXW-1:0] rd;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            fwd_a;
    logic            fwd_b;
  } slot_t;
endpackage

// File: rtl/regfile.sv
// Register file: two operand read ports, one debug read port,
// one synchronous write port; r0 is never written so reads 0.
module regfile
  import constants::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic [IDXW-1:0] ra_i,
  input  logic [IDXW-1:0] rb_i,
  input  logic [IDXW-1:0] dbg_addr_i,
  input  logic            we_i,
  input  logic [IDXW-1:0] wa_i,
  input  logic [W-1:0]    wd_i,
  output logic [W-1:0]    rda_o,
  output logic [W-1:0]    rdb_o,
  output logic [W-1:0]    dbg_o
);
  logic [W-1:0] rf_q [NREGS];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (we_i && wa_i != '0) begin
      rf_q[wa_i] <= wd_i;
    end
  end

  assign rda_o = rf_q[ra_i];
  assign rdb_o = rf_q[rb_i];
  assign dbg_o = rf_q[dbg_addr_i];
endmodule

// File: rtl/alu_issue.sv
// Issue/operand-fetch stage feeding a registered ALU, with write-back.
// ALU_ISSUE_FORWARD_EN: forward from E/W slots instead of stalling.
module alu_issue
  import constants::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [IDXW-1:0] in_rd,
  input  logic [IDXW-1:0] in_rs,
  input  logic [IDXW-1:0] in_rt,
  input  logic            in_imm_en,
  input  logic [W-1:0]    in_imm,
  output logic [3:0]      alu_ctrl,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  input  logic [W-1:0]    alu_y,
  output logic            wb_valid,
  output logic [IDXW-1:0] wb_rd,
  output logic [W-1:0]    wb_data,
  input  logic [IDXW-1:0] dbg_addr,
  output logic [W-1:0]    dbg_data
);
  slot_t           e_q, e_d;
  logic            w_vld_q;
  logic [IDXW-1:0] w_rd_q;
  logic [W-1:0]    rs_data, rt_data;
  logic            rs_nz, rt_nz;
  logic            rs_e, rs_w, rt_e, rt_w;
  logic            acc;

  regfile u_rf (
    .clk        (clk),
    .resetn     (resetn),
    .ra_i       (in_rs),
    .rb_i       (in_rt),
    .dbg_addr_i (dbg_addr),
    .we_i       (w_vld_q),
    .wa_i       (w_rd_q),
    .wd_i       (alu_y),
    .rda_o      (rs_data),
    .rdb_o      (rt_data),
    .dbg_o      (dbg_data)
  );

  assign rs_nz = in_rs != '0;
  assign rt_nz = (in_rt != '0) && !in_imm_en;
  assign rs_e  = rs_nz && e_q.valid && (in_rs == e_q.rd);
  assign rt_e  = rt_nz && e_q.valid && (in_rt == e_q.rd);
  assign rs_w  = rs_nz && w_vld_q && (in_rs == w_rd_q);
  assign rt_w  = rt_nz && w_vld_q && (in_rt == w_rd_q);

`ifdef ALU_ISSUE_FORWARD_EN
  assign in_ready = 1'b1;
`else
  assign in_ready = !(rs_e || rs_w || rt_e || rt_w);
`endif
  assign acc = in_valid && in_ready;

  always_comb begin
    e_d = '0;
    if (acc) begin
      e_d.valid = 1'b1;
      e_d.op    = in_op;
      e_d.rd    = in_rd;
      e_d.a     = rs_data;
      e_d.b     = in_imm_en ? in_imm : rt_data;
`ifdef ALU_ISSUE_FORWARD_EN
      // E holds the youngest producer, so it beats W
      if (rs_e)      e_d.fwd_a = 1'b1;
      else if (rs_w) e_d.a     = alu_y;
      if (rt_e)      e_d.fwd_b = 1'b1;
      else if (rt_w) e_d.b     = alu_y;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_q     <= '0;
      w_vld_q <= 1'b0;
      w_rd_q  <= '0;
    end else begin
      e_q     <= e_d;
      w_vld_q <= e_q.valid;
      w_rd_q  <= e_q.rd;
    end
  end

  assign alu_ctrl = e_q.op;
  assign alu_a    = e_q.fwd_a ? alu_y : e_q.a;
  assign alu_b    = e_q.fwd_b ? alu_y : e_q.b;
  assign wb_valid = w_vld_q;
  assign wb_rd    = w_rd_q;
  assign wb_data  = w_vld_q ? alu_y : '0;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a registered ALU model.
// Stall expectations follow the ALU_ISSUE_FORWARD_EN build.
module tb_alu_issue;
  import constants::*;

`ifdef ALU_ISSUE_FORWARD_EN
  localparam int STL = 0;
`else
  localparam int STL = 2;
`endif

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      in_op = '0;
  logic [IDXW-1:0] in_rd = '0, in_rs = '0, in_rt = '0;
  logic            in_imm_en = 1'b0;
  logic [W-1:0]    in_imm = '0;
  logic [3:0]      alu_ctrl;
  logic [W-1:0]    alu_a, alu_b, alu_y;
  logic            wb_valid;
  logic [IDXW-1:0] wb_rd;
  logic [W-1:0]    wb_data;
  logic [IDXW-1:0] dbg_addr = '0;
  logic [W-1:0]    dbg_data;

  int npass = 0;
  int ntot  = 0;
  int st;
  logic [IDXW+W-1:0] wq[$];

  alu_issue dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_rd    (in_rd),
    .in_rs    (in_rs),
    .in_rt    (in_rt),
    .in_imm_en(in_imm_en),
    .in_imm   (in_imm),
    .alu_ctrl (alu_ctrl),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_y    (alu_y),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) alu_y <= '0;
    else begin
      case (alu_ctrl)
        ALU_OP_ADD: alu_y <= alu_a + alu_b;
        ALU_OP_SUB: alu_y <= alu_a - alu_b;
        ALU_OP_AND: alu_y <= alu_a & alu_b;
        ALU_OP_OR:  alu_y <= alu_a | alu_b;
        ALU_OP_XOR: alu_y <= alu_a ^ alu_b;
        default:    alu_y <= '0;
      endcase
    end
  end

  always @(negedge clk)
    if (wb_valid) wq.push_back({wb_rd, wb_data});

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] rs, input logic [3:0] rt,
                       input logic ie, input logic [15:0] imm,
                       output int stalls);
    in_valid  = 1'b1;
    in_op     = op;
    in_rd     = rd;
    in_rs     = rs;
    in_rt     = rt;
    in_imm_en = ie;
    in_imm    = imm;
    stalls    = 0;
    @(negedge clk);
    while (!in_ready && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) chk("issue_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic peek(input string tag, input logic [3:0] r,
                      input logic [15:0] exp);
    dbg_addr = r;
    #1;
    chk(tag, {16'd0, dbg_data}, {16'd0, exp});
  endtask

  task automatic wbchk(input string tag, input int idx,
                       input logic [3:0] rd, input logic [15:0] d);
    if (idx < wq.size()) chk(tag, {12'd0, wq[idx]}, {12'd0, rd, d});
    else chk(tag, 32'hdead_0000, {12'd0, rd, d});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
    chk("rst_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("rst_ab", {alu_a, alu_b}, 32'd0);
    chk("rst_wb", {12'd0, wb_rd, wb_data}, 32'd0);
    for (int i = 0; i < 16; i++) peek($sformatf("rst_r%0d", i), 4'(i), 16'h0);

    wq.delete();
    issue(ALU_OP_ADD, 1, 0, 0, 1, 16'h0003, st);
    chk("imm1_stall", st, 0);
    issue(ALU_OP_ADD, 2, 0, 0, 1, 16'h0004, st);
    chk("imm2_stall", st, 0);
    issue(ALU_OP_ADD, 3, 1, 2, 0, 16'hffff, st);
    chk("imm3_stall", st, STL);
    idle(5);
    chk("imm_wbn", wq.size(), 3);
    wbchk("imm_wb2", 2, 3, 16'h0007);
    peek("imm_r1", 1, 16'h0003);
    peek("imm_r2", 2, 16'h0004);
    peek("imm_r3", 3, 16'h0007);

    wq.delete();
    issue(ALU_OP_ADD, 1, 0, 0, 1, 16'h7fff, st);
    for (int i = 0; i < 3; i++) begin
      issue(ALU_OP_SUB, 1, 1, 0, 1, 16'h8000, st);
      chk($sformatf("chain_stall%0d", i), st, STL);
    end
    idle(5);
    chk("chain_wbn", wq.size(), 4);
    wbchk("chain_wb0", 0, 1, 16'h7fff);
    wbchk("chain_wb1", 1, 1, 16'hffff);
    wbchk("chain_wb2", 2, 1, 16'h7fff);
    wbchk("chain_wb3", 3, 1, 16'hffff);
    peek("chain_r1", 1, 16'hffff);

    wq.delete();
    issue(ALU_OP_ADD, 0, 0, 0, 1, 16'h1234, st);
    issue(ALU_OP_ADD, 4, 0, 0, 1, 16'h0000, st);
    chk("r0_stall", st, 0);
    idle(5);
    wbchk("r0_wb0", 0, 0, 16'h1234);
    wbchk("r0_wb1", 1, 4, 16'h0000);
    peek("r0_r0", 0, 16'h0000);
    peek("r0_r4", 4, 16'h0000);

    wq.delete();
    issue(ALU_OP_ADD, 5, 0, 0, 1, 16'ha000, st);
    issue(ALU_OP_ADD, 5, 5, 0, 1, 16'h1000, st);
    chk("dual_stall1", st, STL);
    issue(ALU_OP_AND, 6, 5, 5, 0, 16'h0000, st);
    chk("dual_stall2", st, STL);
    idle(5);
    wbchk("dual_wb2", 2, 6, 16'hb000);
    peek("dual_r5", 5, 16'hb000);
    peek("dual_r6", 6, 16'hb000);

    issue(ALU_OP_OR, 8, 0, 0, 1, 16'h00f0, st);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_ctrl", {28'd0, alu_ctrl}, {28'd0, ALU_OP_OR});
    chk("lat_ab", {alu_a, alu_b}, 32'h0000_00f0);
    chk("lat_wbv0", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    chk("lat_wb", {11'd0, wb_valid, wb_rd, wb_data}, {11'd0, 1'b1, 4'd8, 16'h00f0});
    chk("lat_ctrl_idle", {28'd0, alu_ctrl}, 32'd0);
    peek("lat_prewr", 8, 16'h0000);
    @(negedge clk);
    chk("lat_wbv1", {31'd0, wb_valid}, 32'd0);
    peek("lat_postwr", 8, 16'h00f0);

    wq.delete();
    issue(ALU_OP_ADD, 7, 0, 0, 1, 16'h5555, st);
    in_valid = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
    idle(4);
    chk("mid_wbn", wq.size(), 0);
    peek("mid_r7", 7, 16'h0000);
    peek("mid_r8", 8, 16'h0000);
    chk("mid_ready", {31'd0, in_ready}, 32'd1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule
